// File: rtl/hysteresis_detect.sv
// Threshold detector with hysteresis, N-sample confirmation and post-release hold-off.
// Produces a registered detect level, rise/fall pulses, per-detection peak and a saturating event count.
module hysteresis_detect #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED    = 1'b0,
  parameter int CONFIRM   = 4,
  parameter int HOLDOFF   = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     idata,
  input  logic                 ivalid,
  input  logic [WIDTH-1:0]     thr_hi,
  input  logic [WIDTH-1:0]     thr_lo,
  input  logic                 clear,
  output logic                 detect,
  output logic                 rise,
  output logic                 fall,
  output logic [WIDTH-1:0]     peak,
  output logic [CNT_WIDTH-1:0] event_cnt
);

  localparam int RUN_W  = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);
  localparam int HOLD_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CONFIRM, ST_ACTIVE, ST_HOLDOFF} state_t;

  state_t                state, state_next;
  logic [RUN_W-1:0]      run, run_next, run_inc;
  logic [HOLD_W-1:0]     hold, hold_next, hold_inc;
  logic                  detect_next, rise_next, fall_next, enter_active;
  logic [WIDTH-1:0]      peak_next;
  logic [CNT_WIDTH-1:0]  cnt_next;
  logic                  above_hi, below_lo, above_peak;

  function automatic logic greater(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED) return $signed(a) > $signed(b);
    else        return a > b;
  endfunction

  assign above_hi   = greater(idata, thr_hi);
  assign below_lo   = greater(thr_lo, idata);
  assign above_peak = greater(idata, peak);
  assign run_inc    = run + 1'b1;
  assign hold_inc   = hold + 1'b1;

  always_comb begin
    state_next   = state;
    run_next     = run;
    hold_next    = hold;
    detect_next  = detect;
    rise_next    = 1'b0;
    fall_next    = 1'b0;
    peak_next    = peak;
    cnt_next     = event_cnt;
    enter_active = 1'b0;

    if (clear) begin
      state_next  = ST_IDLE;
      run_next    = '0;
      hold_next   = '0;
      detect_next = 1'b0;
      peak_next   = '0;
      cnt_next    = '0;
    end else if (ivalid) begin
      case (state)
        ST_IDLE: begin
          if (above_hi) begin
            peak_next = idata;
            run_next  = RUN_W'(1);
            if (CONFIRM <= 1) enter_active = 1'b1;
            else              state_next   = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (above_hi) begin
            run_next = run_inc;
            if (above_peak) peak_next = idata;
            if (run_inc == RUN_W'(CONFIRM)) enter_active = 1'b1;
          end else begin
            // A single sample at or below thr_hi restarts the run; peak is kept.
            state_next = ST_IDLE;
            run_next   = '0;
          end
        end
        ST_ACTIVE: begin
          if (above_peak) peak_next = idata;
          if (below_lo) begin
            fall_next   = 1'b1;
            detect_next = 1'b0;
            run_next    = '0;
            hold_next   = '0;
            state_next  = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
          end
        end
        default: begin
          if (hold_inc == HOLD_W'(HOLDOFF)) begin
            state_next = ST_IDLE;
            hold_next  = '0;
          end else begin
            hold_next = hold_inc;
          end
        end
      endcase
    end

    if (enter_active) begin
      state_next  = ST_ACTIVE;
      rise_next   = 1'b1;
      detect_next = 1'b1;
      if (event_cnt != '1) cnt_next = event_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      run       <= '0;
      hold      <= '0;
      detect    <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      peak      <= '0;
      event_cnt <= '0;
    end else begin
      state     <= state_next;
      run       <= run_next;
      hold      <= hold_next;
      detect    <= detect_next;
      rise      <= rise_next;
      fall      <= fall_next;
      peak      <= peak_next;
      event_cnt <= cnt_next;
    end
  end

endmodule
